// File: rtl/binomial_filter_pkg.sv
// Shared constants and constant functions for the binomial filter slice.
// Optional feature macro: BINOMIAL_FILTER_ROUND_EN (round-half-up output).
package binomial_filter_pkg;

    localparam int unsigned NUM_ELEM_MIN = 2;
    localparam int unsigned NUM_ELEM_MAX = 16;

    // C(n,k), built multiplicatively; every intermediate step is an exact integer.
    function automatic int unsigned binom(input int unsigned n, input int unsigned k);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < k; i++) begin
            r = (r * (n - i)) / (i + 1);
        end
        return r;
    endfunction

    // Full-precision width of the weighted sum: the weights add up to 2^(num_elem-1).
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ne);
        return dw + ne - 1;
    endfunction

endpackage

// File: rtl/binomial_filter.sv
// Binomial FIR: delay line, weighted sum at full width, registered scaled output.
// Define BINOMIAL_FILTER_ROUND_EN for round-half-up instead of truncation.
module binomial_filter
    import binomial_filter_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned num_elem   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dout
);

    localparam int unsigned NT = num_elem - 1;
`ifdef BINOMIAL_FILTER_ROUND_EN
    // One spare bit so the rounding add can never carry out.
    localparam int unsigned AW = acc_width(data_width, num_elem) + 1;
    localparam logic [AW-1:0] RND = AW'(1) << (NT - 1);
`else
    localparam int unsigned AW = acc_width(data_width, num_elem);
`endif

    if ((num_elem < NUM_ELEM_MIN) || (num_elem > NUM_ELEM_MAX)) begin : g_bad_cfg
        $error("binomial_filter: num_elem out of range 2..16");
    end

    logic [data_width-1:0] tap_q [1:NT];
    logic [AW-1:0]         sum_d;
    logic [data_width-1:0] dout_d;
    logic [data_width-1:0] dout_q;

    // Delay line: tap 1 takes the current input, later taps shift along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '{default: '0};
        end else begin
            tap_q[1] <= din;
            for (int unsigned k = 2; k <= NT; k++) begin
                tap_q[k] <= tap_q[k-1];
            end
        end
    end

    // Weighted window sum (weight of din is C(NT,0)=1) and scaling back to data_width.
    always_comb begin
        sum_d = AW'(din);
        for (int unsigned k = 1; k <= NT; k++) begin
            sum_d = sum_d + AW'(tap_q[k]) * AW'(binom(NT, k));
        end
`ifdef BINOMIAL_FILTER_ROUND_EN
        sum_d = sum_d + RND;
`endif
        dout_d = data_width'(sum_d >> NT);
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/binomial_filter_test.sv
// Test wrapper: free-running up-counter stimulus feeding one binomial_filter.
// Honours BINOMIAL_FILTER_ROUND_EN through the filter sub-module.
module binomial_filter_test
    import binomial_filter_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned num_elem   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [data_width-1:0] outp_inps,
    output logic [data_width-1:0] outp
);

    logic [data_width-1:0] cnt_q;
    logic [data_width-1:0] cnt_d;

    // Next stimulus value, wrapping naturally at the top of the range.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    // Stimulus counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outp_inps = cnt_q;

    binomial_filter #(
        .data_width (data_width),
        .num_elem   (num_elem)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cnt_q),
        .dout  (outp)
    );

endmodule

// File: tb/tb_binomial_filter_test.sv
// Directed bench for binomial_filter_test with num_elem = 2, 3, 4 and 5 instances.
// Expectations follow BINOMIAL_FILTER_ROUND_EN when it is defined.
module tb_binomial_filter_test;

    logic       clk;
    logic       rst_n;
    logic [7:0] inps2, inps3, inps4, inps5;
    logic [7:0] out2, out3, out4, out5;

    int unsigned errors;
    int unsigned checks;

    // Bench model of counter and taps: m[0] = counter, m[k] = tap k.
    int unsigned m [16];

    binomial_filter_test #(.data_width(8), .num_elem(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .outp_inps(inps2), .outp(out2));
    binomial_filter_test #(.data_width(8), .num_elem(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .outp_inps(inps3), .outp(out3));
    binomial_filter_test #(.data_width(8), .num_elem(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .outp_inps(inps4), .outp(out4));
    binomial_filter_test #(.data_width(8), .num_elem(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .outp_inps(inps5), .outp(out5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference filter output from the model window, weights from Pascal's triangle.
    function automatic logic [31:0] ref_out(input int unsigned ne);
        int unsigned row [16];
        int unsigned s;
        for (int i = 0; i < 16; i++) row[i] = 0;
        row[0] = 1;
        for (int r = 1; r < int'(ne); r++) begin
            for (int k = r; k > 0; k--) row[k] = row[k] + row[k-1];
        end
        s = 0;
        for (int k = 0; k < int'(ne); k++) s = s + row[k] * m[k];
`ifdef BINOMIAL_FILTER_ROUND_EN
        s = s + (1 << (ne - 2));
`endif
        return (s >> (ne - 1)) & 32'hFF;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m[i] = 0;
    endtask

    // One clock: predict, advance model, sample 1 time unit after the edge.
    task automatic tick();
        logic [31:0] e2, e3, e4, e5;
        e2 = ref_out(2);
        e3 = ref_out(3);
        e4 = ref_out(4);
        e5 = ref_out(5);
        @(posedge clk);
        for (int k = 15; k > 0; k--) m[k] = m[k-1];
        m[0] = (m[0] + 1) % 256;
        #1;
        check("inps3", inps3, m[0]);
        check("inps5", inps5, m[0]);
        check("model2", out2, e2);
        check("model3", out3, e3);
        check("model4", out4, e4);
        check("model5", out5, e5);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_inps3"}, inps3, 0);
        check({tag, "_out2"}, out2, 0);
        check({tag, "_out3"}, out3, 0);
        check({tag, "_out4"}, out4, 0);
        check({tag, "_out5"}, out5, 0);
    endtask

    int unsigned start_inps [5];
    int unsigned start_out  [5];
    int unsigned wrap_inps  [5];
    int unsigned wrap_out   [5];
    int unsigned guard;
    int unsigned lag2;
    int unsigned lag4;

    initial begin
        errors = 0;
        checks = 0;
        start_inps = '{1, 2, 3, 4, 5};
        start_out  = '{0, 0, 1, 2, 3};
        wrap_inps  = '{0, 1, 2, 3, 4};
        wrap_out   = '{254, 191, 64, 1, 2};
`ifdef BINOMIAL_FILTER_ROUND_EN
        lag2 = 1;
        lag4 = 2;
`else
        lag2 = 2;
        lag4 = 3;
`endif
        clear_model();

        // Power-up reset.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;

        // First five edges after release.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("start_inps", inps3, start_inps[i]);
            check("start_out", out3, start_out[i]);
        end

        // Run to c=100, checking steady-ramp lag for 2 and 4 taps on the way.
        guard = 0;
        while (m[0] != 100 && guard < 300) begin
            tick();
            guard++;
            if (m[0] >= 50 && m[0] < 54) begin
                check("lag2", out2, (m[0] - lag2) & 32'hFF);
                check("lag4", out4, (m[0] - lag4) & 32'hFF);
            end
        end
        check("reach100", m[0], 100);

        // Asynchronous reset pulse away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("restart_inps", inps3, start_inps[i]);
            check("restart_out", out3, start_out[i]);
        end

        // Wrap-around of the stimulus counter.
        guard = 0;
        while (m[0] != 255 && guard < 300) begin
            tick();
            guard++;
        end
        check("reach255", inps3, 255);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wrap_inps", inps3, wrap_inps[i]);
            check("wrap_out", out3, wrap_out[i]);
        end

        // Long free run against the model.
        for (int i = 0; i < 512; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/binomial_filter_test.md
BINOMIAL_FILTER_TEST -- requirements
Module: binomial_filter_test

Interface
REQ-001 The block SHALL have parameter data_width, default 8, giving the bit width of the stimulus sample and of the filter output.
REQ-002 The block SHALL have parameter num_elem, default 3, giving the filter tap count; legal range 2..16, with an elaboration error outside that range.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: outp_inps  output  data_width  current internally generated stimulus sample.
REQ-007 Port: outp  output  data_width  registered binomial-filtered result.

Function
REQ-008 The stimulus SHALL be a data_width-bit up-counter c; c <= c+1 every clock, wrapping modulo 2^data_width (max value to 0).
REQ-009 outp_inps SHALL equal c directly (register output, no added logic delay).
REQ-010 The block SHALL have a delay line t[1..num_elem-1], where t[1] <= c and t[k] <= t[k-1] on every clock.
REQ-011 The filter window SHALL be w[0]=c and w[k]=t[k]; the weights SHALL be binomial coefficients C(num_elem-1,k), for example 1,2,1 for num_elem=3 and 1,3,3,1 for num_elem=4.
REQ-012 The sum S=sum(C(num_elem-1,k)*w[k]) SHALL be computed at full width data_width+num_elem-1 bits, unsigned, with no overflow.
REQ-013 On every clock, outp <= S >> (num_elem-1), truncated to data_width bits; the result always fits without saturation.
REQ-014 Latency: outp SHALL reflect the window present one clock earlier; for num_elem=3 in steady-state ramp, outp = outp_inps-2.
REQ-015 Wrap-around SHALL be handled in the same way as any other value: taps keep the pre-wrap values and there is no special-casing.

Reset
REQ-016 While rst_n=0, the block SHALL immediately (asynchronously) hold c=0, all t[k]=0 and outp=0.
REQ-017 Reset asserted mid-operation SHALL discard all history; after release the sequence restarts exactly as from power-up.
REQ-018 The first rising edge with rst_n=1 SHALL produce c=1 and outp=F(0,0,...)=0.

Configuration
REQ-019 Macro BINOMIAL_FILTER_ROUND_EN: when defined, outp <= (S + 2^(num_elem-2)) >> (num_elem-1), which is round-half-up, and the adder SHALL be wide enough that the rounding add does not overflow.
REQ-020 When BINOMIAL_FILTER_ROUND_EN is not defined, outp SHALL use plain truncation as in REQ-013.

Structure
REQ-021 A shared package binomial_filter_pkg SHALL hold the constant function returning C(n,k), the accumulator-width function and the tap-count limits.
REQ-022 The filter SHALL be a sub-module binomial_filter (parameters data_width and num_elem; ports clk, rst_n, din, dout), containing the delay line, the weighted sum and the output register.
REQ-023 binomial_filter_test SHALL contain only the stimulus counter and one instance of binomial_filter, with din driven by c.

Verification
REQ-024 Reset then release, num_elem=3, width 8 -> (outp_inps, outp) after edges 1..5: (1,0), (2,0), (3,1), (4,2), (5,3).
REQ-025 Wrap, num_elem=3 -> after the edges following c=255: (0,254), (1,191), (2,64), (3,1), (4,2).
REQ-026 rst_n pulsed low mid-run at c=100 -> outp and outp_inps go to 0 immediately, without waiting for a clock edge, and the REQ-024 sequence then repeats.
REQ-027 num_elem=2, steady ramp at outp_inps=v -> outp=v-2 when truncating, and v-1 with BINOMIAL_FILTER_ROUND_EN defined.
REQ-028 num_elem=4, steady ramp at outp_inps=v -> outp=v-3 when truncating, and v-2 with BINOMIAL_FILTER_ROUND_EN defined.
REQ-029 Across a 512-cycle free run for num_elem=3 and for num_elem=5, a reference model of REQ-011 to REQ-013 SHALL match outp on every cycle, with no X values after reset.
